// File: rtl/tmax_report_reader.sv
// =============================================================================
// Module      : tmax_report_reader
// Description : Walks Tmax store slots 1..N_TARGETS on frame_end and streams
//               header, per-slot words and a checksum trailer over valid/ready.
//               Optional macro TMAX_CLEAR_ON_READ_EN clears each slot after read.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tmax_report_reader #(
    parameter int N_TARGETS = 15,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_end,
    input  logic [9:0]  Ttemp,
    output logic [3:0]  Number,
    output logic        BUSY,
    output logic        clr,
    output logic [15:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        overrun
);

    localparam logic [15:0] c_hdr_word = 16'hF000 | 16'(N_TARGETS);
    localparam logic [3:0]  c_last_num = 4'(N_TARGETS);
    localparam logic [1:0]  c_lat_last = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_WAIT = 3'd2,
        S_CAP  = 3'd3,
        S_SEND = 3'd4,
        S_CLR  = 3'd5,
        S_NEXT = 3'd6,
        S_TRL  = 3'd7
    } state_t;

    state_t      r_state;
    logic [3:0]  r_number;
    logic        r_busy;
    logic [15:0] r_dout;
    logic        r_dout_valid;
    logic        r_overrun;
    logic        r_pending;
    logic [9:0]  r_cksum;
    logic [1:0]  r_lat_cnt;
`ifdef TMAX_CLEAR_ON_READ_EN
    logic        r_clr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_number     <= 4'd0;
            r_busy       <= 1'b0;
            r_dout       <= 16'd0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_pending    <= 1'b0;
            r_cksum      <= 10'd0;
            r_lat_cnt    <= 2'd0;
`ifdef TMAX_CLEAR_ON_READ_EN
            r_clr        <= 1'b0;
`endif
        end else begin
`ifdef TMAX_CLEAR_ON_READ_EN
            r_clr <= 1'b0;
`endif
            // One-deep request queue; a second request while one waits is lost.
            if (r_state != S_IDLE && frame_end) begin
                if (r_pending)
                    r_overrun <= 1'b1;
                else
                    r_pending <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (frame_end || r_pending) begin
                        // A fresh pulse arriving as the queued one is consumed stays queued.
                        r_pending    <= r_pending & frame_end;
                        r_busy       <= 1'b1;
                        r_cksum      <= 10'd0;
                        r_dout       <= c_hdr_word;
                        r_dout_valid <= 1'b1;
                        r_state      <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_number     <= 4'd1;
                        r_lat_cnt    <= 2'd0;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt == c_lat_last)
                        r_state <= S_CAP;
                    else
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                end
                S_CAP: begin
                    r_dout       <= {r_number, 2'b00, Ttemp};
                    r_dout_valid <= 1'b1;
                    r_cksum      <= r_cksum + Ttemp;
                    r_state      <= S_SEND;
                end
                S_SEND: begin
                    if (dout_ready) begin
                        r_dout_valid <= 1'b0;
`ifdef TMAX_CLEAR_ON_READ_EN
                        r_clr        <= 1'b1;
                        r_state      <= S_CLR;
`else
                        r_state      <= S_NEXT;
`endif
                    end
                end
                S_CLR: begin
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_number < c_last_num) begin
                        r_number  <= r_number + 4'd1;
                        r_lat_cnt <= 2'd0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_dout       <= {6'b111000, r_cksum};
                        r_dout_valid <= 1'b1;
                        r_state      <= S_TRL;
                    end
                end
                S_TRL: begin
                    if (dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_number     <= 4'd0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Number     = r_number;
    assign BUSY       = r_busy;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;
`ifdef TMAX_CLEAR_ON_READ_EN
    assign clr        = r_clr;
`else
    assign clr        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tmax_report_reader.sv
// =============================================================================
// Module      : tb_tmax_report_reader
// Description : Directed bench; two readers (RD_LAT 1 and 3) each on a store model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_tmax_report_reader;

`ifdef TMAX_CLEAR_ON_READ_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_end = 1'b0;
    logic        ready1 = 1'b1;
    logic        ready3 = 1'b1;
    logic        load = 1'b0;
    logic [9:0]  ttemp1, ttemp3;
    logic [3:0]  num1, num3;
    logic        busy1, busy3, clr1, clr3, v1, v3, ovr1, ovr3;
    logic [15:0] d1, d3;

    always #5 clk = ~clk;

    tmax_report_reader #(.N_TARGETS(15), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .frame_end(frame_end), .Ttemp(ttemp1),
        .Number(num1), .BUSY(busy1), .clr(clr1), .dout(d1),
        .dout_valid(v1), .dout_ready(ready1), .overrun(ovr1)
    );

    tmax_report_reader #(.N_TARGETS(15), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .frame_end(frame_end), .Ttemp(ttemp3),
        .Number(num3), .BUSY(busy3), .clr(clr3), .dout(d3),
        .dout_valid(v3), .dout_ready(ready3), .overrun(ovr3)
    );

    // Store models: slot k loads k*10, read data delayed by the reader's RD_LAT.
    logic [9:0] mem1 [0:15];
    logic [9:0] mem3 [0:15];
    logic [9:0] pipe1 [0:2];
    logic [9:0] pipe3 [0:2];

    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 16; k++) begin
                mem1[k] <= 10'(k * 10);
                mem3[k] <= 10'(k * 10);
            end
        end else begin
            if (clr1) mem1[num1] <= 10'd0;
            if (clr3) mem3[num3] <= 10'd0;
        end
        pipe1[0] <= mem1[num1];
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
        pipe3[0] <= mem3[num3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign ttemp1 = pipe1[0];
    assign ttemp3 = pipe3[2];

    // Sink monitor: records every transferred word and every clr pulse.
    logic [15:0] q1 [$];
    logic [15:0] q3 [$];
    logic [3:0]  clrq1 [$];
    int          bad_busy1 = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (v1 && ready1) begin
                q1.push_back(d1);
                if (!busy1) bad_busy1 = bad_busy1 + 1;
            end
            if (v3 && ready3) q3.push_back(d3);
            if (clr1) clrq1.push_back(num1);
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_w [0:16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic build_exp(input bit cleared);
        logic [9:0] sum;
        logic [9:0] t;
        sum = 10'd0;
        exp_w[0] = 16'hF00F;
        for (int k = 1; k <= 15; k++) begin
            t = cleared ? 10'd0 : 10'(k * 10);
            exp_w[k] = {4'(k), 2'b00, t};
            sum = sum + t;
        end
        exp_w[16] = {6'b111000, sum};
    endtask

    task automatic compare_report(input bit use3, input int base, input bit cleared, input string tag);
        logic [15:0] obs;
        build_exp(cleared);
        for (int i = 0; i < 17; i++) begin
            if (use3)
                obs = (base + i < q3.size()) ? q3[base + i] : 16'hxxxx;
            else
                obs = (base + i < q1.size()) ? q1[base + i] : 16'hxxxx;
            check($sformatf("%s_w%0d", tag, i), obs, exp_w[i]);
        end
    endtask

    task automatic wait_done(input int n1, input int n3, input int budget, input string tag);
        int c;
        c = 0;
        while (!(q1.size() >= n1 && q3.size() >= n3 && !busy1 && !busy3) && c < budget) begin
            tick();
            c++;
        end
        check({tag, "_timeout"}, 16'(c < budget), 16'd1);
    endtask

    task automatic pulse();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic reload();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_valid1(input string tag);
        int c;
        c = 0;
        while (!v1 && c < 100) begin
            tick();
            c++;
        end
        check(tag, 16'(c < 100), 16'd1);
    endtask

    task automatic accept1();
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
    endtask

    initial begin
        int          b1, b3, cb1;
        logic [15:0] held;

        // Reset values
        repeat (3) tick();
        check("rst_number", 16'(num1), 16'd0);
        check("rst_busy", 16'(busy1), 16'd0);
        check("rst_clr", 16'(clr1), 16'd0);
        check("rst_dout", d1, 16'd0);
        check("rst_valid", 16'(v1), 16'd0);
        check("rst_overrun", 16'(ovr1), 16'd0);
        check("rst_valid3", 16'(v3), 16'd0);
        reset = 1'b0;
        reload();

        // Basic report, both latencies
        b1 = q1.size(); b3 = q3.size();
        pulse();
        wait_done(b1 + 17, b3 + 17, 400, "t1");
        compare_report(1'b0, b1, 1'b0, "t1_lat1");
        compare_report(1'b1, b3, 1'b0, "t1_lat3");
        check("t1_busy_during_words", 16'(bad_busy1), 16'd0);
        check("t1_number_idle", 16'(num1), 16'd0);
        check("t1_busy_idle", 16'(busy1), 16'd0);
        check("t1_count", 16'(q1.size() - b1), 16'd17);

        // Backpressure on slot 3
        reload();
        b1 = q1.size(); b3 = q3.size();
        ready1 = 1'b0;
        pulse();
        for (int w = 0; w < 17; w++) begin
            wait_valid1($sformatf("t2_valid_w%0d", w));
            if (w == 3) begin
                held = d1;
                check("t2_slot3_word", held, 16'h301E);
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check($sformatf("t2_dout_hold%0d", s), d1, held);
                    check($sformatf("t2_num_hold%0d", s), 16'(num1), 16'd3);
                    check($sformatf("t2_valid_hold%0d", s), 16'(v1), 16'd1);
                end
            end
            accept1();
        end
        wait_done(b1 + 17, b3 + 17, 400, "t2");
        compare_report(1'b0, b1, 1'b0, "t2_lat1");
        check("t2_count", 16'(q1.size() - b1), 16'd17);
        ready1 = 1'b1;

        // Pending and overrun
        reload();
        b1 = q1.size(); b3 = q3.size();
        pulse();
        repeat (5) tick();
        pulse();
        repeat (5) tick();
        pulse();
        check("t3_overrun1", 16'(ovr1), 16'd1);
        check("t3_overrun3", 16'(ovr3), 16'd1);
        wait_done(b1 + 34, b3 + 34, 800, "t3");
        compare_report(1'b0, b1, 1'b0, "t3_first");
        compare_report(1'b0, b1 + 17, CLR_EN, "t3_pending");
        compare_report(1'b1, b3 + 17, CLR_EN, "t3_pending_lat3");
        check("t3_count", 16'(q1.size() - b1), 16'd34);
        b1 = q1.size(); b3 = q3.size();
        pulse();
        tick();
        check("t3_overrun_sticky", 16'(ovr1), 16'd1);
        wait_done(b1 + 17, b3 + 17, 400, "t3_idle");
        compare_report(1'b0, b1, CLR_EN, "t3_idle");

        // Reset during slot 7 SEND
        reload();
        ready1 = 1'b0;
        pulse();
        for (int w = 0; w < 7; w++) begin
            wait_valid1($sformatf("t5_valid_w%0d", w));
            accept1();
        end
        wait_valid1("t5_valid_w7");
        check("t5_slot7_word", d1, 16'h7046);
        reset = 1'b1;
        tick();
        check("t5_number", 16'(num1), 16'd0);
        check("t5_busy", 16'(busy1), 16'd0);
        check("t5_clr", 16'(clr1), 16'd0);
        check("t5_dout", d1, 16'd0);
        check("t5_valid", 16'(v1), 16'd0);
        check("t5_overrun", 16'(ovr1), 16'd0);
        check("t5_busy3", 16'(busy3), 16'd0);
        reset = 1'b0;
        ready1 = 1'b1;
        reload();
        b1 = q1.size(); b3 = q3.size();
        pulse();
        wait_done(b1 + 17, b3 + 17, 400, "t5");
        compare_report(1'b0, b1, 1'b0, "t5_restart");
        compare_report(1'b1, b3, 1'b0, "t5_restart_lat3");

        // Clear-on-read behaviour (or its absence)
        reload();
        b1 = q1.size(); b3 = q3.size(); cb1 = clrq1.size();
        pulse();
        wait_done(b1 + 17, b3 + 17, 400, "t6a");
        compare_report(1'b0, b1, 1'b0, "t6_first");
        check("t6_clr_count", 16'(clrq1.size() - cb1), CLR_EN ? 16'd15 : 16'd0);
        for (int i = cb1; i < clrq1.size(); i++)
            check($sformatf("t6_clr_num%0d", i - cb1), 16'(clrq1[i]), 16'(i - cb1 + 1));
        b1 = q1.size(); b3 = q3.size();
        pulse();
        wait_done(b1 + 17, b3 + 17, 400, "t6b");
        compare_report(1'b0, b1, CLR_EN, "t6_second");
        compare_report(1'b1, b3, CLR_EN, "t6_second_lat3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, required finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
